lpc_io_decoder: RTL and testbench

// - LPC bus front end for the CPLD register file: decodes host LPC I/O read/write cycles aimed at a 32-byte window.
// - On a write, presents register offset, write data and a 1-cycle Wr strobe to the register block downstream.
// - On a read, returns the register byte supplied on RdData, driving LAD with SYNC, data and turn-around.
// - Memory, DMA, firmware and bus-master cycles are ignored (never driven).

---
 rtl/lpc_io_decoder.sv | 174 +++++++++++++++++
 tb/tb_lpc_io_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lpc_io_decoder.sv
// lpc_io_decoder
//   Decodes host LPC I/O read and write cycles that fall inside a 32-byte
//   I/O window and bridges them to the CPLD register file. Writes produce
//   a register offset, a data byte and a one-clock Wr strobe. Reads return
//   the byte presented on RdData, using a zero-wait SYNC. Memory, DMA,
//   firmware and bus-master cycles are ignored and never driven.
//
// Parameters
//   BASE_ADDR : I/O window base. Bits [4:0] are ignored.
//
// Ports
//   LpcClock  in   LPC clock (33 MHz)
//   PciReset  in   asynchronous reset, active low
//   LFRAME_N  in   LPC frame, active low
//   LAD_in    in   sampled LAD bus value
//   LAD_out   out  LAD drive value (4'hF when idle)
//   LAD_oe    out  LAD output enable
//   RdData    in   register byte selected by Addr, sampled on reads
//   Addr      out  register offset {3'b000, ioaddr[4:0]}, held until next hit
//   Wr        out  one-clock write strobe
//   DataWrSW  out  write data, valid with Wr and held afterwards
module lpc_io_decoder #(
    parameter logic [15:0] BASE_ADDR = 16'h0800
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LFRAME_N,
    input  logic [3:0] LAD_in,
    output logic [3:0] LAD_out,
    output logic       LAD_oe,
    input  logic [7:0] RdData,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic [7:0] DataWrSW
);

    // Each state is named after the LPC clock it is active in:
    // CYCT=C1, ADDR=C2..C5, WDAT/RTAR=C6..C7, WTAR=C8..C9, RSYNC=C8,
    // RDLO=C9, WSYNC/RDHI=C10, TARD=C11.
    typedef enum logic [3:0] {
        IDLE, CYCT, ADDR, WDAT, WTAR, WSYNC, RTAR, RSYNC, RDLO, RDHI, TARD
    } state_t;

    state_t      state;
    logic [1:0]  nibCnt;
    logic        isWrite;
    logic [11:0] ioAddrHi;   // address nibbles collected so far
    logic [3:0]  rdHi;       // upper read nibble, sent one clock after the lower
    logic [15:0] addrNext;
    logic        addrHit;

    // Full address as it will be once the current nibble is shifted in;
    // at C5 this is the complete I/O address used for the window match.
    assign addrNext = {ioAddrHi, LAD_in};
    assign addrHit  = (addrNext[15:5] == BASE_ADDR[15:5]);

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state    <= IDLE;
            nibCnt   <= 2'd0;
            isWrite  <= 1'b0;
            ioAddrHi <= 12'h000;
            rdHi     <= 4'hF;
            LAD_out  <= 4'hF;
            LAD_oe   <= 1'b0;
            Addr     <= 8'h00;
            Wr       <= 1'b0;
            DataWrSW <= 8'h00;
        end else begin
            Wr <= 1'b0;
            if (!LFRAME_N) begin
                // START or abort: release the bus from the next clock on.
                // The last START clock wins, so a held START just re-enters CYCT.
                LAD_oe  <= 1'b0;
                LAD_out <= 4'hF;
                nibCnt  <= 2'd0;
                state   <= (LAD_in == 4'h0) ? CYCT : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        LAD_oe  <= 1'b0;
                        LAD_out <= 4'hF;
                    end
                    CYCT: begin
                        nibCnt <= 2'd0;
                        if (LAD_in == 4'b0000) begin
                            isWrite <= 1'b0;
                            state   <= ADDR;
                        end else if (LAD_in == 4'b0010) begin
                            isWrite <= 1'b1;
                            state   <= ADDR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    ADDR: begin
                        ioAddrHi <= addrNext[11:0];
                        nibCnt   <= nibCnt + 2'd1;
                        if (nibCnt == 2'd3) begin
                            nibCnt <= 2'd0;
                            if (addrHit) begin
                                Addr  <= {3'b000, addrNext[4:0]};
                                state <= isWrite ? WDAT : RTAR;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    WDAT: begin
                        if (nibCnt == 2'd0) begin
                            DataWrSW[3:0] <= LAD_in;
                            nibCnt        <= 2'd1;
                        end else begin
                            DataWrSW[7:4] <= LAD_in;
                            nibCnt        <= 2'd0;
                            state         <= WTAR;
                        end
                    end
                    WTAR: begin
                        if (nibCnt == 2'd0) begin
                            nibCnt <= 2'd1;
                        end else begin
                            // Strobe coincides with the ready SYNC so an abort
                            // up to and including C9 never writes.
                            nibCnt  <= 2'd0;
                            LAD_oe  <= 1'b1;
                            LAD_out <= 4'h0;
                            Wr      <= 1'b1;
                            state   <= WSYNC;
                        end
                    end
                    WSYNC: begin
                        LAD_out <= 4'hF;
                        state   <= TARD;
                    end
                    RTAR: begin
                        if (nibCnt == 2'd0) begin
                            nibCnt <= 2'd1;
                        end else begin
                            nibCnt  <= 2'd0;
                            LAD_oe  <= 1'b1;
                            LAD_out <= 4'h0;
                            state   <= RSYNC;
                        end
                    end
                    RSYNC: begin
                        LAD_out <= RdData[3:0];
                        rdHi    <= RdData[7:4];
                        state   <= RDLO;
                    end
                    RDLO: begin
                        LAD_out <= rdHi;
                        state   <= RDHI;
                    end
                    RDHI: begin
                        LAD_out <= 4'hF;
                        state   <= TARD;
                    end
                    TARD: begin
                        LAD_oe  <= 1'b0;
                        LAD_out <= 4'hF;
                        state   <= IDLE;
                    end
                    default: begin
                        LAD_oe  <= 1'b0;
                        LAD_out <= 4'hF;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc_io_decoder.sv
// Testbench for lpc_io_decoder: directed vector table, reset and random
// LPC transactions checked clock by clock against a rule-based model.
module tb_lpc_io_decoder;

    localparam logic [15:0] BASE = 16'h0800;
    localparam int NOABORT = 99;

    logic       LpcClock = 1'b0;
    logic       PciReset;
    logic       LFRAME_N;
    logic [3:0] LAD_in;
    logic [3:0] LAD_out;
    logic       LAD_oe;
    logic [7:0] RdData;
    logic [7:0] Addr;
    logic       Wr;
    logic [7:0] DataWrSW;

    int checks = 0;
    int errors = 0;
    logic [7:0] modelAddr = 8'h00;

    lpc_io_decoder #(.BASE_ADDR(BASE)) dut (
        .LpcClock(LpcClock),
        .PciReset(PciReset),
        .LFRAME_N(LFRAME_N),
        .LAD_in(LAD_in),
        .LAD_out(LAD_out),
        .LAD_oe(LAD_oe),
        .RdData(RdData),
        .Addr(Addr),
        .Wr(Wr),
        .DataWrSW(DataWrSW)
    );

    always #15 LpcClock = ~LpcClock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one complete LPC transaction (C0 .. C12) and checks every clock.
    // abortAt: clock at which LFRAME_N is pulled low with a non-START nibble.
    // rstAt: clock at which PciReset is pulsed mid-cycle.
    // noIdle: skip C12 so the next transaction's START lands on C12.
    task automatic doTxn(input logic [3:0] cyc, input logic [15:0] addr,
                         input logic [7:0] data, input logic [7:0] rd,
                         input int abortAt, input int startLen, input int rstAt,
                         input bit noIdle, output int wrSeen);
        bit hit, isW, live, expOe, expWr;
        int last;
        logic [7:0] oldAddr, newAddr, expA;
        logic [3:0] expOut;
        isW     = (cyc == 4'b0010);
        hit     = ((cyc == 4'b0000) || isW) && (addr[15:5] == BASE[15:5]);
        oldAddr = modelAddr;
        newAddr = {3'b000, addr[4:0]};
        RdData  = rd;
        wrSeen  = 0;
        for (int s = 0; s < startLen - 1; s++) begin
            LFRAME_N = 1'b0; LAD_in = 4'h0;
            @(posedge LpcClock); #1;
        end
        last = (abortAt <= 11) ? abortAt + 1 : (noIdle ? 11 : 12);
        for (int n = 0; n <= last; n++) begin
            LFRAME_N = 1'b1;
            LAD_in   = 4'hF;
            if (n > abortAt) begin
                LFRAME_N = 1'b1;
            end else if (n == 0) begin
                LFRAME_N = 1'b0; LAD_in = 4'h0;
            end else if (n == abortAt) begin
                LFRAME_N = 1'b0; LAD_in = 4'hF;
            end else if (n == 1) begin
                LAD_in = cyc;
            end else if (n <= 5) begin
                LAD_in = addr[(5 - n) * 4 +: 4];
            end else if (n == 6 && isW) begin
                LAD_in = data[3:0];
            end else if (n == 7 && isW) begin
                LAD_in = data[7:4];
            end
            if (n == rstAt) begin
                #2 PciReset = 1'b0;
                #1;
                check($sformatf("rst_oe C%0d", n), 8'(LAD_oe), 8'h00);
                check($sformatf("rst_out C%0d", n), 8'(LAD_out), 8'h0F);
                check($sformatf("rst_wr C%0d", n), 8'(Wr), 8'h00);
                check($sformatf("rst_addr C%0d", n), Addr, 8'h00);
                @(posedge LpcClock); #1;
                PciReset = 1'b1; LFRAME_N = 1'b1; LAD_in = 4'hF;
                modelAddr = 8'h00;
                repeat (3) begin
                    @(negedge LpcClock);
                    check("post_rst_oe", 8'(LAD_oe), 8'h00);
                    check("post_rst_wr", 8'(Wr), 8'h00);
                    @(posedge LpcClock); #1;
                end
                return;
            end
            @(negedge LpcClock);
            live   = (n <= abortAt);
            expOe  = hit && live && (isW ? (n == 10 || n == 11) : (n >= 8 && n <= 11));
            expWr  = hit && isW && live && (n == 10);
            expA   = (hit && abortAt > 5 && n >= 6) ? newAddr : oldAddr;
            case (n)
                8:       expOut = 4'h0;
                9:       expOut = rd[3:0];
                10:      expOut = isW ? 4'h0 : rd[7:4];
                default: expOut = 4'hF;
            endcase
            check($sformatf("oe C%0d", n), 8'(LAD_oe), 8'(expOe));
            if (expOe)
                check($sformatf("lad C%0d", n), 8'(LAD_out), 8'(expOut));
            check($sformatf("wr C%0d", n), 8'(Wr), 8'(expWr));
            if (Wr) begin
                wrSeen++;
                check($sformatf("wdata C%0d", n), DataWrSW, data);
            end
            check($sformatf("addr C%0d", n), Addr, expA);
            @(posedge LpcClock); #1;
        end
        if (hit && abortAt > 5)
            modelAddr = newAddr;
    endtask

    typedef struct {
        logic [3:0]  cyc;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  rd;
        int          abortAt;
        int          startLen;
        logic [7:0]  expAddr;
        int          expWr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int w;
        vecs[0] = '{4'b0010, 16'h0809, 8'hA5, 8'h00, NOABORT, 1, 8'h09, 1};
        vecs[1] = '{4'b0000, 16'h0800, 8'h00, 8'h13, NOABORT, 1, 8'h00, 0};
        vecs[2] = '{4'b0010, 16'h0080, 8'h77, 8'h00, NOABORT, 1, 8'h00, 0};
        vecs[3] = '{4'b0110, 16'h0809, 8'h55, 8'h00, NOABORT, 1, 8'h00, 0};
        vecs[4] = '{4'b0010, 16'h080A, 8'h99, 8'h00, 7,       1, 8'h0A, 0};
        vecs[5] = '{4'b0010, 16'h080B, 8'h3C, 8'h00, NOABORT, 1, 8'h0B, 1};
        vecs[6] = '{4'b0000, 16'h081F, 8'h00, 8'hE7, NOABORT, 3, 8'h1F, 0};

        PciReset = 1'b0; LFRAME_N = 1'b1; LAD_in = 4'hF; RdData = 8'h00;
        #40;
        check("reset_oe", 8'(LAD_oe), 8'h00);
        check("reset_out", 8'(LAD_out), 8'h0F);
        check("reset_wr", 8'(Wr), 8'h00);
        check("reset_addr", Addr, 8'h00);
        check("reset_data", DataWrSW, 8'h00);
        @(posedge LpcClock); #1;
        PciReset = 1'b1;
        repeat (2) begin @(posedge LpcClock); #1; end

        for (int i = 0; i < 7; i++) begin
            doTxn(vecs[i].cyc, vecs[i].addr, vecs[i].data, vecs[i].rd,
                  vecs[i].abortAt, vecs[i].startLen, NOABORT, 1'b0, w);
            check($sformatf("vec%0d_addr", i), Addr, vecs[i].expAddr);
            check($sformatf("vec%0d_wrcount", i), 8'(w), 8'(vecs[i].expWr));
            if (vecs[i].expWr != 0)
                check($sformatf("vec%0d_data", i), DataWrSW, vecs[i].data);
        end

        // Reset during C9 of a read, then a normal write.
        doTxn(4'b0000, 16'h0805, 8'h00, 8'h5A, NOABORT, 1, 9, 1'b0, w);
        check("rst_read_wrcount", 8'(w), 8'h00);
        doTxn(4'b0010, 16'h0804, 8'h66, 8'h00, NOABORT, 1, NOABORT, 1'b0, w);
        check("after_rst_addr", Addr, 8'h04);
        check("after_rst_wrcount", 8'(w), 8'h01);
        check("after_rst_data", DataWrSW, 8'h66);

        // Back-to-back: second START lands on C12 of the first.
        doTxn(4'b0010, 16'h0811, 8'hC3, 8'h00, NOABORT, 1, NOABORT, 1'b1, w);
        doTxn(4'b0000, 16'h0812, 8'h00, 8'h4B, NOABORT, 1, NOABORT, 1'b0, w);
        check("b2b_addr", Addr, 8'h12);

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  cyc;
            logic [15:0] addr;
            int          ab;
            case ($urandom_range(0, 5))
                0, 1:    cyc = 4'b0000;
                2, 3:    cyc = 4'b0010;
                default: cyc = 4'($urandom_range(0, 15));
            endcase
            addr = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                addr[15:5] = BASE[15:5];
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : NOABORT;
            doTxn(cyc, addr, 8'($urandom), 8'($urandom), ab,
                  int'($urandom_range(1, 3)), NOABORT, 1'($urandom_range(0, 1)), w);
            check($sformatf("rand%0d_addr", i), Addr, modelAddr);
            repeat ($urandom_range(0, 2)) begin @(posedge LpcClock); #1; end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
